hash_table_assoc: RTL and testbench



---
 rtl/hash_table_assoc_if.sv | 40 ++++
 rtl/hash_table_assoc.sv | 154 +++++++++++++++
 tb/tb_hash_table_assoc.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_table_assoc_if.sv
// hash_table_assoc_if: request/response bundle for the set-associative hash table
//   master: drives req_valid_i/req_op_i/req_key_i/req_val_i and resp_ready_i
//   slave : drives req_ready_o, resp_valid_o/resp_code_o/resp_val_o, busy_o
//   occupancy_o exists only when HASH_TABLE_ASSOC_STATS_EN is defined
interface hash_table_assoc_if #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 16,
    parameter int IDX_W = 10,
    parameter int WAYS  = 2
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_op_i;
    logic [KEY_W-1:0] req_key_i;
    logic [VAL_W-1:0] req_val_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [1:0]       resp_code_o;
    logic [VAL_W-1:0] resp_val_o;
    logic             busy_o;
`ifdef HASH_TABLE_ASSOC_STATS_EN
    logic [IDX_W+$clog2(WAYS):0] occupancy_o;
`endif

    modport master (
        output req_valid_i, req_op_i, req_key_i, req_val_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_code_o, resp_val_o, busy_o
`ifdef HASH_TABLE_ASSOC_STATS_EN
        , input occupancy_o
`endif
    );

    modport slave (
        input  req_valid_i, req_op_i, req_key_i, req_val_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_code_o, resp_val_o, busy_o
`ifdef HASH_TABLE_ASSOC_STATS_EN
        , output occupancy_o
`endif
    );
endinterface

// File: rtl/hash_table_assoc.sv
// hash_table_assoc: set-associative exact-match hash table (lookup/insert/delete)
//   clk, rst : clock, synchronous active-high reset (restarts the clearing sweep)
//   bus      : hash_table_assoc_if.slave request/response handshakes
//   Optional macro HASH_TABLE_ASSOC_STATS_EN adds bus.occupancy_o (valid entry count)
module hash_table_assoc #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 16,
    parameter int IDX_W = 10,
    parameter int WAYS  = 2
) (
    input logic clk,
    input logic rst,
    hash_table_assoc_if.slave bus
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NCH   = (KEY_W + IDX_W - 1) / IDX_W;
    localparam int ENT_W = 1 + KEY_W + VAL_W;
    localparam logic [1:0] C_MISS = 2'd0, C_HIT = 2'd1, C_INS = 2'd2, C_FULL = 2'd3;

    typedef enum logic [2:0] {INIT, IDLE, RD, CMP, RESP} state_t;
    state_t state, state_n;

    logic [IDX_W-1:0] cnt, idx_q;
    logic [1:0]       op_q;
    logic [KEY_W-1:0] key_q;
    logic [VAL_W-1:0] val_q;
    logic [1:0]       code_q, code_c;
    logic [VAL_W-1:0] rval_q, val_c, hit_val;
    logic [ENT_W-1:0] rd_data [WAYS];
    logic [ENT_W-1:0] wd, wr_ent;
    logic [IDX_W-1:0] wa;
    logic             hit, free, wr;
    logic [WW-1:0]    hit_way, free_way, wr_way;

    // XOR-fold of the key in IDX_W-bit chunks; the top chunk is zero-padded
    function automatic logic [IDX_W-1:0] hash(input logic [KEY_W-1:0] key);
        logic [NCH*IDX_W-1:0] pad;
        logic [IDX_W-1:0]     h;
        pad = (NCH*IDX_W)'(key);
        h = '0;
        for (int i = 0; i < NCH; i++) h ^= pad[i*IDX_W +: IDX_W];
        return h;
    endfunction

    // One synchronous-read RAM per way; INIT clears, CMP commits the op's write
    assign wa = (state == INIT) ? cnt : idx_q;
    assign wd = (state == INIT) ? '0 : wr_ent;
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [ENT_W-1:0] mem [DEPTH];
        logic [ENT_W-1:0] q;
        logic             we;
        assign we = (state == INIT) || (state == CMP && wr && wr_way == WW'(w));
        always_ff @(posedge clk) begin
            if (we) mem[wa] <= wd;
            q <= mem[idx_q];
        end
        assign rd_data[w] = q;
    end

    // Scan downward so the lowest matching / lowest invalid way wins
    always_comb begin
        hit = 1'b0;
        free = 1'b0;
        hit_way = '0;
        free_way = '0;
        hit_val = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (rd_data[i][ENT_W-1] && rd_data[i][KEY_W+VAL_W-1:VAL_W] == key_q) begin
                hit = 1'b1;
                hit_way = WW'(i);
                hit_val = rd_data[i][VAL_W-1:0];
            end
            if (!rd_data[i][ENT_W-1]) begin
                free = 1'b1;
                free_way = WW'(i);
            end
        end
    end

    // Response and write decision; op 3 falls through as a lookup
    always_comb begin
        code_c = hit ? C_HIT : C_MISS;
        val_c = hit ? hit_val : '0;
        wr = 1'b0;
        wr_way = hit_way;
        wr_ent = {1'b1, key_q, val_q};
        if (op_q == 2'd1) begin
            wr = hit || free;
            wr_way = hit ? hit_way : free_way;
            code_c = hit ? C_HIT : (free ? C_INS : C_FULL);
        end else if (op_q == 2'd2) begin
            wr = hit;
            wr_ent = {1'b0, key_q, hit_val};
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            INIT:    state_n = (&cnt) ? IDLE : INIT;
            IDLE:    state_n = bus.req_valid_i ? RD : IDLE;
            RD:      state_n = CMP;
            CMP:     state_n = RESP;
            RESP:    state_n = bus.resp_ready_i ? IDLE : RESP;
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx_q <= '0;
            op_q <= '0;
            key_q <= '0;
            val_q <= '0;
            code_q <= '0;
            rval_q <= '0;
        end else begin
            if (state == INIT) cnt <= cnt + 1'b1;
            if (state == IDLE && bus.req_valid_i) begin
                op_q <= bus.req_op_i;
                key_q <= bus.req_key_i;
                val_q <= bus.req_val_i;
                idx_q <= hash(bus.req_key_i);
            end
            if (state == CMP) begin
                code_q <= code_c;
                rval_q <= val_c;
            end
        end
    end

`ifdef HASH_TABLE_ASSOC_STATS_EN
    logic [IDX_W+$clog2(WAYS):0] occ;
    always_ff @(posedge clk) begin
        if (rst || state == INIT) occ <= '0;
        else if (state == CMP && op_q == 2'd1 && code_c == C_INS) occ <= occ + 1'b1;
        else if (state == CMP && op_q == 2'd2 && hit) occ <= occ - 1'b1;
    end
    assign bus.occupancy_o = occ;
`endif

    assign bus.req_ready_o  = (state == IDLE);
    assign bus.resp_valid_o = (state == RESP);
    assign bus.busy_o       = (state != IDLE);
    assign bus.resp_code_o  = code_q;
    assign bus.resp_val_o   = rval_q;
endmodule

// File: tb/tb_hash_table_assoc.sv
// tb_hash_table_assoc: self-checking bench for hash_table_assoc against a key/value model
module tb_hash_table_assoc;
    localparam int KEY_W = 32, VAL_W = 16, IDX_W = 10, WAYS = 2;
    localparam logic [1:0] LK = 2'd0, INS = 2'd1, DEL = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errs = 0;
    int checks = 0;

    logic [VAL_W-1:0] mdl [logic [KEY_W-1:0]];
    int bcnt [1 << IDX_W];

    hash_table_assoc_if #(.KEY_W(KEY_W), .VAL_W(VAL_W), .IDX_W(IDX_W), .WAYS(WAYS)) bus ();
    hash_table_assoc #(.KEY_W(KEY_W), .VAL_W(VAL_W), .IDX_W(IDX_W), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int mhash(input logic [31:0] k);
        int h = 0;
        for (int i = 0; i < 4; i++) h ^= int'((k >> (10 * i)) & 32'h3FF);
        return h;
    endfunction

    task automatic model_clear();
        mdl.delete();
        for (int i = 0; i < (1 << IDX_W); i++) bcnt[i] = 0;
    endtask

    // Bucket holds up to WAYS distinct keys; codes 0 MISS 1 HIT 2 INSERTED 3 FULL
    task automatic model_op(input logic [1:0] op, input logic [31:0] k, input logic [15:0] v,
                            output logic [1:0] code, output logic [15:0] rv);
        int h = mhash(k);
        bit p = mdl.exists(k);
        code = p ? 2'd1 : 2'd0;
        rv = p ? mdl[k] : 16'h0;
        if (op == INS) begin
            if (p) mdl[k] = v;
            else if (bcnt[h] < WAYS) begin
                mdl[k] = v;
                bcnt[h]++;
                code = 2'd2;
            end else code = 2'd3;
        end else if (op == DEL && p) begin
            mdl.delete(k);
            bcnt[h]--;
        end
    endtask

    task automatic op_run(input logic [1:0] op, input logic [31:0] k, input logic [15:0] v,
                          input int hold, output logic [1:0] code, output logic [15:0] rv,
                          output int lat, output bit stable, output bit rdy_after);
        int n = 0;
        bus.req_valid_i = 1'b1;
        bus.req_op_i = op;
        bus.req_key_i = k;
        bus.req_val_i = v;
        while (!bus.req_ready_o && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout: req_ready_o never rose after %0d cycles", n);
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.resp_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        code = bus.resp_code_o;
        rv = bus.resp_val_o;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!bus.resp_valid_o || bus.resp_code_o !== code || bus.resp_val_o !== rv || bus.req_ready_o)
                stable = 1'b0;
        end
        bus.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready_i = 1'b0;
        rdy_after = bus.req_ready_o;
    endtask

    task automatic test_reset();
        int n = 0;
        logic [1:0] c, ec;
        logic [15:0] v, ev;
        int lat;
        bit st, ra;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b1 ||
            bus.resp_code_o !== 2'd0 || bus.resp_val_o !== 16'h0) begin
            errs++;
            $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b code=%0d val=%h, want 0 0 1 0 0",
                     bus.req_ready_o, bus.resp_valid_o, bus.busy_o, bus.resp_code_o, bus.resp_val_o);
        end
`ifdef HASH_TABLE_ASSOC_STATS_EN
        checks++;
        if (bus.occupancy_o !== 0) begin
            errs++;
            $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy_o);
        end
`endif
        model_clear();
        bus.req_valid_i = 1'b1;
        bus.req_op_i = LK;
        bus.req_key_i = 32'h0A000001;
        rst = 1'b0;
        while (!bus.req_ready_o && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 1024) begin
            errs++;
            $display("FAIL init_length: ready low for %0d cycles, want 1024", n);
        end
        op_run(LK, 32'h0A000001, 16'h0, 0, c, v, lat, st, ra);
        model_op(LK, 32'h0A000001, 16'h0, ec, ev);
        checks++;
        if (c !== ec || v !== ev) begin
            errs++;
            $display("FAIL first_lookup: code=%0d val=%h want code=%0d val=%h", c, v, ec, ev);
        end
    endtask

    task automatic run_table(input string name, input logic [1:0] ops[], input logic [31:0] keys[],
                             input logic [15:0] vals[]);
        logic [1:0] c, ec;
        logic [15:0] v, ev;
        int lat;
        bit st, ra;
        for (int i = 0; i < ops.size(); i++) begin
            op_run(ops[i], keys[i], vals[i], 0, c, v, lat, st, ra);
            model_op(ops[i], keys[i], vals[i], ec, ev);
            checks++;
            if (c !== ec || v !== ev || lat != 3 || ra !== 1'b1) begin
                errs++;
                $display("FAIL %s[%0d]: code=%0d val=%h lat=%0d rdy=%b want code=%0d val=%h lat=3 rdy=1",
                         name, i, c, v, lat, ra, ec, ev);
            end
`ifdef HASH_TABLE_ASSOC_STATS_EN
            checks++;
            if (bus.occupancy_o !== mdl.num()) begin
                errs++;
                $display("FAIL %s_occ[%0d]: got %0d want %0d", name, i, bus.occupancy_o, mdl.num());
            end
`endif
        end
    endtask

    task automatic test_insert_lookup();
        run_table("insert_lookup", '{INS, LK}, '{32'h005, 32'h005}, '{16'h1111, 16'h0});
        checks++;
        if (mdl[32'h005] !== 16'h1111) begin
            errs++;
            $display("FAIL insert_model: got %h want 1111", mdl[32'h005]);
        end
    endtask

    task automatic test_collision();
        run_table("collision", '{DEL, INS, INS, INS, LK, LK},
                  '{32'h005, 32'h005, 32'h404, 32'hC06, 32'hC06, 32'h404},
                  '{16'h0, 16'h1, 16'h2, 16'h3, 16'h0, 16'h0});
    endtask

    task automatic test_overwrite_delete();
        run_table("overwrite_delete", '{INS, LK, DEL, DEL, INS},
                  '{32'h005, 32'h005, 32'h005, 32'h005, 32'hC06},
                  '{16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h3});
    endtask

    task automatic test_stall();
        logic [1:0] c, ec;
        logic [15:0] v, ev;
        int lat;
        bit st, ra;
        op_run(LK, 32'h404, 16'h0, 10, c, v, lat, st, ra);
        model_op(LK, 32'h404, 16'h0, ec, ev);
        checks++;
        if (c !== ec || v !== ev) begin
            errs++;
            $display("FAIL stall_resp: code=%0d val=%h want code=%0d val=%h", c, v, ec, ev);
        end
        checks++;
        if (st !== 1'b1) begin
            errs++;
            $display("FAIL stall_hold: stable=%b want 1", st);
        end
        checks++;
        if (ra !== 1'b1) begin
            errs++;
            $display("FAIL stall_release: req_ready_o=%b after handshake want 1", ra);
        end
    endtask

    task automatic test_back_to_back();
        run_table("back_to_back", '{INS, DEL, INS, LK, 2'd3, DEL},
                  '{32'h1C07, 32'h1C07, 32'h1C07, 32'h1C07, 32'h1C07, 32'h1C07},
                  '{16'hA5A5, 16'h0, 16'h5A5A, 16'h0, 16'h0, 16'h0});
    endtask

    task automatic test_random();
        logic [1:0] c, ec, op;
        logic [15:0] v, ev, val;
        logic [31:0] k;
        int lat;
        bit st, ra;
        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(0, 3));
            k = ($urandom_range(0, 9) < 8) ? ((32'($urandom_range(0, 7)) << 10) | 32'($urandom_range(0, 3)))
                                          : $urandom;
            val = 16'($urandom);
            op_run(op, k, val, 0, c, v, lat, st, ra);
            model_op(op, k, val, ec, ev);
            checks++;
            if (c !== ec || v !== ev || lat != 3) begin
                errs++;
                $display("FAIL random[%0d] op=%0d key=%h: code=%0d val=%h lat=%0d want code=%0d val=%h lat=3",
                         i, op, k, c, v, lat, ec, ev);
            end
`ifdef HASH_TABLE_ASSOC_STATS_EN
            checks++;
            if (bus.occupancy_o !== mdl.num()) begin
                errs++;
                $display("FAIL random_occ[%0d]: got %0d want %0d", i, bus.occupancy_o, mdl.num());
            end
`endif
        end
    endtask

    task automatic test_reset_abort();
        int n = 0;
        bit bad = 1'b0;
        logic [1:0] c;
        logic [15:0] v;
        int lat;
        bit st, ra;
        bus.req_valid_i = 1'b1;
        bus.req_op_i = INS;
        bus.req_key_i = 32'h0000_7777;
        bus.req_val_i = 16'h7777;
        while (!bus.req_ready_o && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b0 || bus.busy_o !== 1'b1 ||
                bus.resp_code_o !== 2'd0 || bus.resp_val_o !== 16'h0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errs++;
            $display("FAIL abort_outputs: vld=%b rdy=%b busy=%b code=%0d val=%h want 0 0 1 0 0",
                     bus.resp_valid_o, bus.req_ready_o, bus.busy_o, bus.resp_code_o, bus.resp_val_o);
        end
        rst = 1'b0;
        model_clear();
        op_run(LK, 32'h0000_7777, 16'h0, 0, c, v, lat, st, ra);
        checks++;
        if (c !== 2'd0 || v !== 16'h0) begin
            errs++;
            $display("FAIL abort_lookup: code=%0d val=%h want code=0 val=0000", c, v);
        end
        op_run(LK, 32'h404, 16'h0, 0, c, v, lat, st, ra);
        checks++;
        if (c !== 2'd0) begin
            errs++;
            $display("FAIL abort_cleared: code=%0d want 0", c);
        end
`ifdef HASH_TABLE_ASSOC_STATS_EN
        checks++;
        if (bus.occupancy_o !== 0) begin
            errs++;
            $display("FAIL abort_occupancy: got %0d want 0", bus.occupancy_o);
        end
`endif
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_op_i = 2'd0;
        bus.req_key_i = '0;
        bus.req_val_i = '0;
        bus.resp_ready_i = 1'b0;
        test_reset();
        test_insert_lookup();
        test_collision();
        test_overwrite_delete();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
